// File: rtl/debug_run_ctrl.sv
// Run/step controller: turns host STEP-N / RUN commands into spaced single-cycle step pulses.
// Optional macro RUN_CTRL_EBREAK_HALT_EN: also stop (cause 2) when the current instruction is EBREAK.
module debug_run_ctrl #(
    parameter int unsigned STEP_GAP = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_run,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      current_pc,
    input  logic [31:0]      current_instruction,
    output logic             step,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned GAP_W = $clog2(STEP_GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_e;

    typedef enum logic [1:0] {
        C_NONE  = 2'd0,
        C_COUNT = 2'd1,
        C_BREAK = 2'd2,
        C_HOST  = 2'd3
    } cause_e;

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               hold_q, hold_d;
    logic               step_q, step_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               halted_q, halted_d;
    logic               stop;
    cause_e             stop_cause;

`ifndef RUN_CTRL_EBREAK_HALT_EN
    logic unused_insn;
    assign unused_insn = ^current_instruction;
`endif

    // Stop decision for the last GAP cycle; a halt_req on this very cycle counts.
    always_comb begin
        stop       = 1'b1;
        stop_cause = C_NONE;
        if (hold_q || halt_req) begin
            stop_cause = C_HOST;
        end else if (bp_en && (current_pc == bp_addr)) begin
            stop_cause = C_BREAK;
`ifdef RUN_CTRL_EBREAK_HALT_EN
        end else if (current_instruction == 32'h0010_0073) begin
            stop_cause = C_BREAK;
`endif
        end else if (!mode_q && (remaining_q == '0)) begin
            stop_cause = C_COUNT;
        end else begin
            stop = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        mode_d      = mode_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        gap_d       = gap_q;
        hold_d      = hold_q;
        step_d      = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;
        halted_d    = halted_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d      = cmd_run;
                    remaining_d = cmd_count;
                    count_d     = '0;
                    cause_d     = C_NONE;
                    halted_d    = 1'b0;
                    hold_d      = 1'b0;
                    if (!cmd_run && (cmd_count == '0)) begin
                        halted_d = 1'b1;
                        cause_d  = C_COUNT;
                    end else begin
                        // First pulse is counted on entry so step_count tracks the visible pulse.
                        state_d = S_PULSE;
                        step_d  = 1'b1;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        count_d = CNT_W'(1);
                        if (!cmd_run) begin
                            remaining_d = cmd_count - CNT_W'(1);
                        end
                    end
                end
            end

            S_PULSE: begin
                state_d = S_GAP;
                gap_d   = GAP_W'(STEP_GAP - 2);
                if (halt_req) begin
                    hold_d = 1'b1;
                end
            end

            S_GAP: begin
                if (halt_req) begin
                    hold_d = 1'b1;
                end
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (stop) begin
                    state_d  = S_IDLE;
                    cause_d  = stop_cause;
                    halted_d = 1'b1;
                    busy_d   = 1'b0;
                    ready_d  = 1'b1;
                    hold_d   = 1'b0;
                end else begin
                    state_d = S_PULSE;
                    step_d  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (!mode_q && (remaining_q != '0)) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cause_q     <= C_NONE;
            mode_q      <= 1'b0;
            remaining_q <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            hold_q      <= 1'b0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            halted_q    <= halted_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign step       = step_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Scoreboard bench for debug_run_ctrl: stimulus queues expected completions, a negedge monitor checks them.
module tb_debug_run_ctrl;

    localparam int unsigned GAP = 4;
    localparam int unsigned CW  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_run;
    logic [CW-1:0] cmd_count;
    logic          halt_req;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic [31:0]   current_pc;
    logic [31:0]   current_instruction;
    logic          step;
    logic          busy;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] step_count;

    always #5 clk = ~clk;

    debug_run_ctrl #(.STEP_GAP(GAP), .CNT_W(CW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_run             (cmd_run),
        .cmd_count           (cmd_count),
        .halt_req            (halt_req),
        .bp_en               (bp_en),
        .bp_addr             (bp_addr),
        .current_pc          (current_pc),
        .current_instruction (current_instruction),
        .step                (step),
        .busy                (busy),
        .halted              (halted),
        .halt_cause          (halt_cause),
        .step_count          (step_count)
    );

    // Wrapper model: each step pulse advances the PC by 4 at the end of the pulse cycle.
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic [31:0] ebreak_pc;
    always @(posedge clk) begin
        if (pc_load)   current_pc <= pc_load_val;
        else if (step) current_pc <= current_pc + 32'd4;
    end
    assign current_instruction = (current_pc == ebreak_pc) ? 32'h0010_0073 : 32'h0000_0013;

    typedef struct {
        int cause;
        int count;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    logic pending = 1'b0;
    logic prev_step = 1'b0;
    int   acc_edge = 0;
    int   pulses = 0;
    int   last_pulse = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!reset_n) begin
            pending   = 1'b0;
            prev_step = 1'b0;
        end else begin
            if (step) begin
                check("step_width", int'(prev_step), 0);
                if (pulses > 0) check("step_period", cyc - last_pulse, GAP);
                pulses++;
                last_pulse = cyc;
            end
            prev_step = step;
            if (pending && cyc >= acc_edge && halted && !busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("halt_cause", int'(halt_cause), e.cause);
                    check("step_count", int'(step_count), e.count);
                    check("pulses_seen", pulses, e.count);
                    if (e.lat >= 0) check("halt_latency", cyc - acc_edge, e.lat);
                end
                pending = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                pending  = 1'b1;
                acc_edge = cyc + 1;
                pulses   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic run, input int count, input logic push,
                         input int ecause, input int ecount, input int elat);
        exp_t x;
        bit   done;
        done = 0;
        cmd_valid = 1'b1;
        cmd_run   = run;
        cmd_count = CW'(count);
        if (push) begin
            x.cause = ecause;
            x.count = ecount;
            x.lat   = elat;
            sb.push_back(x);
        end
        for (int i = 0; i < 50 && !done; i++) begin
            if (cmd_ready) done = 1;
            tick();
        end
        if (!done) check("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) return;
            tick();
        end
        check("done_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_step"},       int'(step), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_cmd_ready"},  int'(cmd_ready), 1);
        check({tag, "_halted"},     int'(halted), 0);
        check({tag, "_halt_cause"}, int'(halt_cause), 0);
        check({tag, "_step_count"}, int'(step_count), 0);
    endtask

    int n;

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_run     = 1'b0;
        cmd_count   = '0;
        halt_req    = 1'b0;
        bp_en       = 1'b0;
        bp_addr     = 32'h0;
        pc_load     = 1'b1;
        pc_load_val = 32'h0;
        ebreak_pc   = 32'hFFFF_FFFC;
        repeat (3) tick();
        check_reset_outputs("rst");
        pc_load = 1'b0;
        reset_n = 1'b1;
        tick();

        // STEP 3; a command offered while busy must be held off.
        issue(1'b0, 3, 1'b1, 1, 3, 3 * GAP);
        cmd_valid = 1'b1;
        cmd_count = CW'(7);
        repeat (3) begin
            tick();
            check("busy_ready", int'(cmd_ready), 0);
            check("busy_busy", int'(busy), 1);
        end
        cmd_valid = 1'b0;
        wait_done();

        // halt_req while idle is ignored.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        check("idle_halt_halted", int'(halted), 1);
        check("idle_halt_cause", int'(halt_cause), 1);
        issue(1'b0, 1, 1'b1, 1, 1, GAP);
        wait_done();

        // STEP 0: no pulse, done one cycle after accept.
        issue(1'b0, 0, 1'b1, 1, 0, 0);
        wait_done();

        // RUN into a breakpoint at 0x10 from PC 0.
        pc_load = 1'b1; pc_load_val = 32'h0;
        tick();
        pc_load = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        issue(1'b1, 0, 1'b1, 2, 4, 4 * GAP);
        wait_done();
        // RUN from the breakpoint PC still pulses; host halt during the pulse stops it.
        issue(1'b1, 0, 1'b1, 3, 1, GAP);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_done();
        bp_en = 1'b0;

        // RUN, host halt in the second GAP.
        issue(1'b1, 0, 1'b1, 3, 2, 2 * GAP);
        n = 1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            tick();
            if (step) n++;
        end
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_done();

        // Host halt arriving exactly on the decision cycle.
        issue(1'b0, 2, 1'b1, 3, 1, GAP);
        repeat (3) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_done();

        // EBREAK fetched after the first step.
        pc_load = 1'b1; pc_load_val = 32'h0;
        tick();
        pc_load   = 1'b0;
        ebreak_pc = 32'h4;
`ifdef RUN_CTRL_EBREAK_HALT_EN
        issue(1'b0, 3, 1'b1, 2, 1, GAP);
`else
        issue(1'b0, 3, 1'b1, 1, 3, 3 * GAP);
`endif
        wait_done();
        ebreak_pc = 32'hFFFF_FFFC;

        // Reset asserted during a pulse cycle.
        issue(1'b0, 5, 1'b0, 0, 0, 0);
        check("pulse_before_reset", int'(step), 1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        tick();
        check("post_rst_step", int'(step), 0);
        check("post_rst_busy", int'(busy), 0);

        wait_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
